// File: rtl/cdb_lane_arbiter_pkg.sv
// Shared defaults and helpers for the common-data-bus lane arbiter.
// Default geometry: 8 functional units broadcast over 2 lanes.
package cdb_lane_arbiter_pkg;
   localparam int FU_NUM_DEF    = 8;
   localparam int LANES_DEF     = 2;
   localparam int WORD_SIZE_DEF = 32;
   localparam int RB_INDEX_DEF  = 4;
   localparam int FU_INDEX_DEF  = 3;

   // Modulo for sums known to be below 2*modulus (round-robin pointer arithmetic).
   function automatic int wrap_idx(input int value, input int modulus);
      return (value >= modulus) ? value - modulus : value;
   endfunction
endpackage

// File: rtl/cdb_lane_arbiter_if.sv
// FU result channels on one side, broadcast CDB lanes on the other.
// The arbiter is the slave; the FU cluster / consumers form the master side.
interface cdb_lane_arbiter_if
   import cdb_lane_arbiter_pkg::*;
#(
   parameter int FU_NUM    = FU_NUM_DEF,
   parameter int LANES     = LANES_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int RB_INDEX  = RB_INDEX_DEF,
   parameter int FU_INDEX  = FU_INDEX_DEF
) ();
   logic [FU_NUM-1:0]           fu_valid;
   logic [FU_NUM-1:0]           fu_ready;
   logic [FU_NUM*WORD_SIZE-1:0] fu_data;
   logic [FU_NUM*WORD_SIZE-1:0] fu_addr;
   logic [FU_NUM*RB_INDEX-1:0]  fu_rb_index;
   logic [LANES-1:0]            cdb_valid;
   logic [LANES*WORD_SIZE-1:0]  cdb_data;
   logic [LANES*WORD_SIZE-1:0]  cdb_addr;
   logic [LANES*RB_INDEX-1:0]   cdb_rb_index;
   logic [LANES*FU_INDEX-1:0]   cdb_src_fu;
   logic [FU_INDEX:0]           pending_cnt;

   modport master (
      output fu_valid, fu_data, fu_addr, fu_rb_index,
      input  fu_ready, cdb_valid, cdb_data, cdb_addr, cdb_rb_index, cdb_src_fu, pending_cnt
   );

   modport slave (
      input  fu_valid, fu_data, fu_addr, fu_rb_index,
      output fu_ready, cdb_valid, cdb_data, cdb_addr, cdb_rb_index, cdb_src_fu, pending_cnt
   );
endinterface

// File: rtl/cdb_lane_arbiter_rr_multi_pick.sv
// Combinational round-robin picker granting up to LANES requesters per cycle,
// starting the scan at ptr; the k-th grant found goes to lane k.
module cdb_lane_arbiter_rr_multi_pick
   import cdb_lane_arbiter_pkg::*;
#(
   parameter int FU_NUM   = FU_NUM_DEF,
   parameter int LANES    = LANES_DEF,
   parameter int FU_INDEX = FU_INDEX_DEF
) (
   input  logic [FU_NUM-1:0]              req,
   input  logic [FU_INDEX-1:0]            ptr,
   output logic [LANES-1:0][FU_NUM-1:0]   grant_oh,
   output logic [LANES-1:0]               lane_valid,
   output logic [LANES-1:0][FU_INDEX-1:0] lane_idx,
   output logic                           any_grant,
   output logic [FU_INDEX-1:0]            last_idx
);
   logic [FU_NUM-1:0] rot_req;
   logic [FU_NUM-1:0] remaining;
   int                pos;
   int                idx;
   logic              found;

   // Rotate so that bit 0 is the slot the pointer names.
   always_comb begin
      rot_req = '0;
      for (int j = 0; j < FU_NUM; j++) begin
         rot_req[j] = req[FU_INDEX'(wrap_idx(j + int'(ptr), FU_NUM))];
      end
   end

   always_comb begin
      remaining  = rot_req;
      grant_oh   = '0;
      lane_valid = '0;
      lane_idx   = '0;
      any_grant  = 1'b0;
      last_idx   = '0;
      pos        = 0;
      idx        = 0;
      found      = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         pos   = 0;
         found = 1'b0;
         for (int j = FU_NUM - 1; j >= 0; j--) begin
            if (remaining[j]) begin
               pos   = j;
               found = 1'b1;
            end
         end
         idx = wrap_idx(pos + int'(ptr), FU_NUM);
         if (found) begin
            remaining[FU_INDEX'(pos)]    = 1'b0;
            grant_oh[l][FU_INDEX'(idx)] = 1'b1;
            lane_valid[l]               = 1'b1;
            lane_idx[l]                 = FU_INDEX'(idx);
            any_grant                   = 1'b1;
            last_idx                    = FU_INDEX'(idx);
         end
      end
   end
endmodule

// File: rtl/cdb_lane_arbiter.sv
// Collects FU results into one-entry slots and broadcasts up to LANES of them
// per cycle on registered CDB lanes, round-robin, with mispredict flush.
module cdb_lane_arbiter
   import cdb_lane_arbiter_pkg::*;
#(
   parameter int FU_NUM    = FU_NUM_DEF,
   parameter int LANES     = LANES_DEF,
   parameter int WORD_SIZE = WORD_SIZE_DEF,
   parameter int RB_INDEX  = RB_INDEX_DEF,
   parameter int FU_INDEX  = FU_INDEX_DEF
) (
   input logic               clk,
   input logic               reset,
   input logic               flush,
   cdb_lane_arbiter_if.slave bus
);
   logic [FU_NUM-1:0]             pend_reg;
   logic [FU_NUM-1:0]             pend_next;
   logic [FU_NUM-1:0]             ready_vec;
   logic [FU_NUM-1:0]             capture;
   logic [FU_NUM-1:0]             grant_vec;
   logic [WORD_SIZE-1:0]          slot_data_reg [FU_NUM];
   logic [WORD_SIZE-1:0]          slot_addr_reg [FU_NUM];
   logic [RB_INDEX-1:0]           slot_rb_reg   [FU_NUM];
   logic [FU_INDEX-1:0]           rr_ptr_reg;

   logic [LANES-1:0][FU_NUM-1:0]   grant_oh;
   logic [LANES-1:0]               lane_valid;
   logic [LANES-1:0][FU_INDEX-1:0] lane_idx;
   logic                           any_grant;
   logic [FU_INDEX-1:0]            last_idx;

   logic [LANES*WORD_SIZE-1:0]    cdb_data_next;
   logic [LANES*WORD_SIZE-1:0]    cdb_addr_next;
   logic [LANES*RB_INDEX-1:0]     cdb_rb_next;
   logic [LANES*FU_INDEX-1:0]     cdb_src_next;

   logic [LANES-1:0]              cdb_valid_reg;
   logic [LANES*WORD_SIZE-1:0]    cdb_data_reg;
   logic [LANES*WORD_SIZE-1:0]    cdb_addr_reg;
   logic [LANES*RB_INDEX-1:0]     cdb_rb_reg;
   logic [LANES*FU_INDEX-1:0]     cdb_src_reg;
   logic [FU_INDEX:0]             pending_cnt_reg;

   cdb_lane_arbiter_rr_multi_pick #(
      .FU_NUM   (FU_NUM),
      .LANES    (LANES),
      .FU_INDEX (FU_INDEX)
   ) u_pick (
      .req        (pend_reg),
      .ptr        (rr_ptr_reg),
      .grant_oh   (grant_oh),
      .lane_valid (lane_valid),
      .lane_idx   (lane_idx),
      .any_grant  (any_grant),
      .last_idx   (last_idx)
   );

   always_comb begin
      grant_vec = '0;
      for (int l = 0; l < LANES; l++) begin
         grant_vec = grant_vec | grant_oh[l];
      end
   end

   // A granted slot empties at this edge, so it may take a new result at the same time.
   generate
      for (genvar gi = 0; gi < FU_NUM; gi++) begin : g_slot
         assign ready_vec[gi] = reset & ~flush & (~pend_reg[gi] | grant_vec[gi]);
         assign capture[gi]   = bus.fu_valid[gi] & ready_vec[gi];
         assign pend_next[gi] = (pend_reg[gi] & ~grant_vec[gi]) | capture[gi];

         always_ff @(posedge clk) begin
            if (capture[gi]) begin
               slot_data_reg[gi] <= bus.fu_data[gi*WORD_SIZE +: WORD_SIZE];
               slot_addr_reg[gi] <= bus.fu_addr[gi*WORD_SIZE +: WORD_SIZE];
               slot_rb_reg[gi]   <= bus.fu_rb_index[gi*RB_INDEX +: RB_INDEX];
            end
         end
      end
   endgenerate

   always_comb begin
      cdb_data_next = '0;
      cdb_addr_next = '0;
      cdb_rb_next   = '0;
      cdb_src_next  = '0;
      for (int l = 0; l < LANES; l++) begin
         if (lane_valid[l]) begin
            cdb_data_next[l*WORD_SIZE +: WORD_SIZE] = slot_data_reg[lane_idx[l]];
            cdb_addr_next[l*WORD_SIZE +: WORD_SIZE] = slot_addr_reg[lane_idx[l]];
            cdb_rb_next[l*RB_INDEX +: RB_INDEX]     = slot_rb_reg[lane_idx[l]];
            cdb_src_next[l*FU_INDEX +: FU_INDEX]    = lane_idx[l];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_reg        <= '0;
         rr_ptr_reg      <= '0;
         cdb_valid_reg   <= '0;
         cdb_data_reg    <= '0;
         cdb_addr_reg    <= '0;
         cdb_rb_reg      <= '0;
         cdb_src_reg     <= '0;
         pending_cnt_reg <= '0;
      end else if (flush) begin
         // Pointer deliberately keeps its position across a flush.
         pend_reg        <= '0;
         cdb_valid_reg   <= '0;
         cdb_data_reg    <= '0;
         cdb_addr_reg    <= '0;
         cdb_rb_reg      <= '0;
         cdb_src_reg     <= '0;
         pending_cnt_reg <= '0;
      end else begin
         pend_reg        <= pend_next;
         cdb_valid_reg   <= lane_valid;
         cdb_data_reg    <= cdb_data_next;
         cdb_addr_reg    <= cdb_addr_next;
         cdb_rb_reg      <= cdb_rb_next;
         cdb_src_reg     <= cdb_src_next;
         pending_cnt_reg <= (FU_INDEX+1)'($countones(pend_next));
         if (any_grant) begin
            rr_ptr_reg <= FU_INDEX'(wrap_idx(int'(last_idx) + 1, FU_NUM));
         end
      end
   end

   assign bus.fu_ready     = ready_vec;
   assign bus.cdb_valid    = cdb_valid_reg;
   assign bus.cdb_data     = cdb_data_reg;
   assign bus.cdb_addr     = cdb_addr_reg;
   assign bus.cdb_rb_index = cdb_rb_reg;
   assign bus.cdb_src_fu   = cdb_src_reg;
   assign bus.pending_cnt  = pending_cnt_reg;
endmodule

// File: tb/tb_cdb_lane_arbiter.sv
// Scenario bench for cdb_lane_arbiter (8 FUs, 2 lanes) with a queue-based
// reference model of slot occupancy and round-robin broadcast order.
module tb_cdb_lane_arbiter;
   localparam int N  = 8;
   localparam int L  = 2;
   localparam int W  = 32;
   localparam int RB = 4;
   localparam int FI = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   cdb_lane_arbiter_if #(.FU_NUM(N), .LANES(L), .WORD_SIZE(W), .RB_INDEX(RB), .FU_INDEX(FI)) bus ();

   cdb_lane_arbiter #(.FU_NUM(N), .LANES(L), .WORD_SIZE(W), .RB_INDEX(RB), .FU_INDEX(FI)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: per-FU held result, pointer, and a queue of this cycle's winners.
   bit           m_pend    [N];
   bit           m_granted [N];
   logic [W-1:0] m_data    [N];
   logic [W-1:0] m_addr    [N];
   logic [RB-1:0] m_rb     [N];
   int           m_ptr = 0;
   int           grant_q[$];

   logic [L-1:0]    e_valid = '0;
   logic [L*W-1:0]  e_data  = '0;
   logic [L*W-1:0]  e_addr  = '0;
   logic [L*RB-1:0] e_rb    = '0;
   logic [L*FI-1:0] e_src   = '0;
   logic [FI:0]     e_cnt   = '0;
   logic [N-1:0]    e_ready = '0;
   logic [N-1:0]    ready_seen;

   function automatic void model_pick();
      grant_q.delete();
      for (int i = 0; i < N; i++) m_granted[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx = (m_ptr + k) % N;
         if (m_pend[idx] && grant_q.size() < L) begin
            grant_q.push_back(idx);
            m_granted[idx] = 1'b1;
         end
      end
   endfunction

   task automatic set_inputs(input logic [N-1:0] v);
      bus.fu_valid = v;
      for (int i = 0; i < N; i++) begin
         bus.fu_data[i*W +: W]       = $urandom;
         bus.fu_addr[i*W +: W]       = $urandom;
         bus.fu_rb_index[i*RB +: RB] = RB'($urandom);
      end
   endtask

   // Advance one clock: sample fu_ready before the edge, step the model at the edge.
   task automatic tick();
      #1;
      ready_seen = bus.fu_ready;
      model_pick();
      for (int i = 0; i < N; i++) e_ready[i] = reset && !flush && (!m_pend[i] || m_granted[i]);
      @(posedge clk);
      e_valid = '0; e_data = '0; e_addr = '0; e_rb = '0; e_src = '0;
      if (!reset) begin
         for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
         m_ptr = 0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      end else begin
         foreach (grant_q[k]) begin
            int idx = grant_q[k];
            e_valid[k]            = 1'b1;
            e_data[k*W +: W]      = m_data[idx];
            e_addr[k*W +: W]      = m_addr[idx];
            e_rb[k*RB +: RB]      = m_rb[idx];
            e_src[k*FI +: FI]     = FI'(idx);
            m_pend[idx]           = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (bus.fu_valid[i] && e_ready[i]) begin
               m_pend[i] = 1'b1;
               m_data[i] = bus.fu_data[i*W +: W];
               m_addr[i] = bus.fu_addr[i*W +: W];
               m_rb[i]   = bus.fu_rb_index[i*RB +: RB];
            end
         end
         if (grant_q.size() > 0) m_ptr = (grant_q[grant_q.size()-1] + 1) % N;
      end
      e_cnt = '0;
      for (int i = 0; i < N; i++) e_cnt = e_cnt + (FI+1)'(m_pend[i]);
      #1;
   endtask

   task automatic pulse_reset();
      set_inputs('0);
      flush = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set_inputs(N'($urandom));
      repeat (2) begin
         tick();
         checks++;
         if (ready_seen !== '0) begin failures++; $display("FAIL reset_ready act=%h exp=00", ready_seen); end
         checks++;
         if (bus.cdb_valid !== '0 || bus.pending_cnt !== '0 || bus.cdb_data !== '0) begin
            failures++; $display("FAIL reset_outputs act v=%b cnt=%0d exp v=00 cnt=0", bus.cdb_valid, bus.pending_cnt);
         end
      end
      reset = 1'b1;
      set_inputs('0);
      tick();
      checks++;
      if (ready_seen !== 8'hFF) begin failures++; $display("FAIL release_ready act=%h exp=ff", ready_seen); end
      checks++;
      if (bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd0 || dut.rr_ptr_reg !== 3'd0) begin
         failures++; $display("FAIL release_state act v=%b cnt=%0d ptr=%0d exp v=00 cnt=0 ptr=0", bus.cdb_valid, bus.pending_cnt, dut.rr_ptr_reg);
      end
   endtask

   task automatic test_single();
      set_inputs(8'b0000_1000);
      bus.fu_data[3*W +: W]       = 32'h0000_00A5;
      bus.fu_rb_index[3*RB +: RB] = 4'd5;
      tick();
      checks++;
      if (ready_seen[3] !== 1'b1 || bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd1) begin
         failures++; $display("FAIL single_capture act rdy3=%b v=%b cnt=%0d exp rdy3=1 v=00 cnt=1", ready_seen[3], bus.cdb_valid, bus.pending_cnt);
      end
      set_inputs('0);
      tick();
      checks++;
      if (bus.cdb_valid !== 2'b01 || bus.cdb_data[31:0] !== 32'hA5 || bus.cdb_rb_index[3:0] !== 4'd5 ||
          bus.cdb_src_fu[2:0] !== 3'd3 || bus.cdb_data[63:32] !== 32'h0) begin
         failures++; $display("FAIL single_bcast act v=%b d=%h rb=%0d src=%0d exp v=01 d=a5 rb=5 src=3",
                              bus.cdb_valid, bus.cdb_data[31:0], bus.cdb_rb_index[3:0], bus.cdb_src_fu[2:0]);
      end
      checks++;
      if (dut.rr_ptr_reg !== 3'd4) begin failures++; $display("FAIL single_ptr act=%0d exp=4", dut.rr_ptr_reg); end
      tick();
      checks++;
      if (bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd0) begin
         failures++; $display("FAIL single_oneshot act v=%b cnt=%0d exp v=00 cnt=0", bus.cdb_valid, bus.pending_cnt);
      end
   endtask

   task automatic test_multi();
      pulse_reset();
      set_inputs(8'b0100_0110);
      tick();
      checks++;
      if (bus.pending_cnt !== 4'd3 || bus.cdb_valid !== 2'b00) begin
         failures++; $display("FAIL multi_cnt3 act cnt=%0d v=%b exp cnt=3 v=00", bus.pending_cnt, bus.cdb_valid);
      end
      set_inputs('0);
      tick();
      checks++;
      if (bus.cdb_valid !== 2'b11 || bus.cdb_src_fu !== {3'd2, 3'd1} || bus.pending_cnt !== 4'd1 || bus.cdb_data !== e_data) begin
         failures++; $display("FAIL multi_cycle1 act v=%b src=%h cnt=%0d exp v=11 src=%h cnt=1", bus.cdb_valid, bus.cdb_src_fu, bus.pending_cnt, {3'd2, 3'd1});
      end
      tick();
      checks++;
      if (bus.cdb_valid !== 2'b01 || bus.cdb_src_fu[2:0] !== 3'd6 || bus.pending_cnt !== 4'd0 || bus.cdb_data !== e_data) begin
         failures++; $display("FAIL multi_cycle2 act v=%b src0=%0d cnt=%0d exp v=01 src0=6 cnt=0", bus.cdb_valid, bus.cdb_src_fu[2:0], bus.pending_cnt);
      end
      checks++;
      if (dut.rr_ptr_reg !== 3'd7) begin failures++; $display("FAIL multi_ptr act=%0d exp=7", dut.rr_ptr_reg); end
   endtask

   task automatic test_fairness();
      int last_seen [N];
      int pair;
      int s;
      for (int i = 0; i < N; i++) last_seen[i] = -1;
      pulse_reset();
      for (int c = 0; c < 11; c++) begin
         set_inputs('1);
         tick();
         if (c >= 1) begin
            pair = (c - 1) % 4;
            checks++;
            if (bus.cdb_valid !== 2'b11 || bus.cdb_src_fu[2:0] !== FI'(2*pair) || bus.cdb_src_fu[5:3] !== FI'(2*pair+1) || bus.pending_cnt !== 4'd8) begin
               failures++; $display("FAIL fair_pair c=%0d act v=%b src=%0d,%0d cnt=%0d exp v=11 src=%0d,%0d cnt=8",
                                    c, bus.cdb_valid, bus.cdb_src_fu[2:0], bus.cdb_src_fu[5:3], bus.pending_cnt, 2*pair, 2*pair+1);
            end
            checks++;
            if (bus.cdb_data !== e_data || bus.cdb_addr !== e_addr || bus.cdb_rb_index !== e_rb) begin
               failures++; $display("FAIL fair_payload c=%0d act d=%h rb=%h exp d=%h rb=%h", c, bus.cdb_data, bus.cdb_rb_index, e_data, e_rb);
            end
            for (int l = 0; l < L; l++) begin
               s = int'(bus.cdb_src_fu[l*FI +: FI]);
               if (last_seen[s] >= 0) begin
                  checks++;
                  if (c - last_seen[s] != 4) begin
                     failures++; $display("FAIL fair_gap fu=%0d act=%0d exp=4", s, c - last_seen[s]);
                  end
               end
               last_seen[s] = c;
            end
         end
      end
   endtask

   task automatic test_refill();
      pulse_reset();
      set_inputs(8'b0010_0000);
      bus.fu_rb_index[5*RB +: RB] = 4'd3;
      tick();
      set_inputs(8'b0010_0000);
      bus.fu_rb_index[5*RB +: RB] = 4'd9;
      tick();
      checks++;
      if (ready_seen[5] !== 1'b1) begin failures++; $display("FAIL refill_ready act=%b exp=1", ready_seen[5]); end
      checks++;
      if (bus.cdb_valid !== 2'b01 || bus.cdb_src_fu[2:0] !== 3'd5 || bus.cdb_rb_index[3:0] !== 4'd3 || bus.pending_cnt !== 4'd1) begin
         failures++; $display("FAIL refill_old act v=%b src=%0d rb=%0d cnt=%0d exp v=01 src=5 rb=3 cnt=1",
                              bus.cdb_valid, bus.cdb_src_fu[2:0], bus.cdb_rb_index[3:0], bus.pending_cnt);
      end
      set_inputs('0);
      tick();
      checks++;
      if (bus.cdb_valid !== 2'b01 || bus.cdb_src_fu[2:0] !== 3'd5 || bus.cdb_rb_index[3:0] !== 4'd9 || bus.pending_cnt !== 4'd0) begin
         failures++; $display("FAIL refill_new act v=%b src=%0d rb=%0d cnt=%0d exp v=01 src=5 rb=9 cnt=0",
                              bus.cdb_valid, bus.cdb_src_fu[2:0], bus.cdb_rb_index[3:0], bus.pending_cnt);
      end
   endtask

   task automatic test_flush();
      pulse_reset();
      set_inputs(8'b0000_0100); tick();
      set_inputs('0);           tick();
      set_inputs(8'b0011_1110); tick();
      set_inputs(8'b1100_0000); tick();
      checks++;
      if (bus.cdb_valid !== 2'b11 || bus.pending_cnt !== 4'd5 || dut.rr_ptr_reg !== 3'd5) begin
         failures++; $display("FAIL flush_setup act v=%b cnt=%0d ptr=%0d exp v=11 cnt=5 ptr=5", bus.cdb_valid, bus.pending_cnt, dut.rr_ptr_reg);
      end
      flush = 1'b1;
      set_inputs(8'b0000_0001);
      tick();
      flush = 1'b0;
      checks++;
      if (ready_seen !== '0) begin failures++; $display("FAIL flush_ready act=%h exp=00", ready_seen); end
      checks++;
      if (bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd0 || dut.rr_ptr_reg !== 3'd5) begin
         failures++; $display("FAIL flush_state act v=%b cnt=%0d ptr=%0d exp v=00 cnt=0 ptr=5", bus.cdb_valid, bus.pending_cnt, dut.rr_ptr_reg);
      end
      set_inputs('0);
      repeat (3) begin
         tick();
         checks++;
         if (bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd0) begin
            failures++; $display("FAIL flush_dropped act v=%b cnt=%0d exp v=00 cnt=0", bus.cdb_valid, bus.pending_cnt);
         end
      end
      set_inputs('1); tick();
      set_inputs('0); tick();
      reset = 1'b0;
      set_inputs(8'b0000_0001);
      tick();
      checks++;
      if (ready_seen !== '0 || bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd0 || dut.rr_ptr_reg !== 3'd0) begin
         failures++; $display("FAIL midburst_reset act rdy=%h v=%b cnt=%0d ptr=%0d exp rdy=00 v=00 cnt=0 ptr=0",
                              ready_seen, bus.cdb_valid, bus.pending_cnt, dut.rr_ptr_reg);
      end
      reset = 1'b1;
      set_inputs('0);
      tick();
      checks++;
      if (bus.cdb_valid !== 2'b00 || bus.pending_cnt !== 4'd0) begin
         failures++; $display("FAIL midburst_after act v=%b cnt=%0d exp v=00 cnt=0", bus.cdb_valid, bus.pending_cnt);
      end
   endtask

   task automatic test_random();
      pulse_reset();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 99) != 0);
         flush = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 1) == 1) set_inputs(N'($urandom));
         else                           set_inputs(N'($urandom) & N'($urandom) & N'($urandom));
         tick();
         checks++;
         if (ready_seen !== e_ready) begin
            failures++; $display("FAIL rand_ready c=%0d act=%h exp=%h", c, ready_seen, e_ready);
         end
         checks++;
         if ({bus.cdb_valid, bus.cdb_data, bus.cdb_addr, bus.cdb_rb_index, bus.cdb_src_fu, bus.pending_cnt} !==
             {e_valid, e_data, e_addr, e_rb, e_src, e_cnt}) begin
            failures++; $display("FAIL rand_cdb c=%0d act v=%b d=%h rb=%h src=%h cnt=%0d exp v=%b d=%h rb=%h src=%h cnt=%0d",
                                 c, bus.cdb_valid, bus.cdb_data, bus.cdb_rb_index, bus.cdb_src_fu, bus.pending_cnt,
                                 e_valid, e_data, e_rb, e_src, e_cnt);
         end
         checks++;
         if (dut.rr_ptr_reg !== FI'(m_ptr)) begin
            failures++; $display("FAIL rand_ptr c=%0d act=%0d exp=%0d", c, dut.rr_ptr_reg, m_ptr);
         end
      end
      reset = 1'b1;
      flush = 1'b0;
   endtask

   initial begin
      set_inputs('0);
      test_reset();
      test_single();
      test_multi();
      test_fairness();
      test_refill();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
